iter_divider: RTL and testbench

//  - Multi-cycle integer divider for the ALU execute stage.
//  - The CLA group logic builds sums. This block is the inverse datapath: a

---
 rtl/div_pkg.sv | 20 ++
 rtl/iter_sub_cla.sv | 76 +++++++
 rtl/iter_divider.sv | 154 +++++++++++++++
 tb/tb_iter_divider.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state type for the iterative divider (iter_divider, iter_sub_cla).
package div_pkg;

    localparam int unsigned DIV_WIDTH = 16;
    localparam int unsigned DIV_GRP_W = 4;

    function automatic int unsigned div_cnt_w(input int unsigned w);
        return $clog2(w);
    endfunction

    localparam int unsigned          DIV_CNT_W  = div_cnt_w(DIV_WIDTH);
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/iter_sub_cla.sv
// W-bit subtractor a_i - b_i from 4-bit lookahead groups and a second-level group carry.
module iter_sub_cla
    import div_pkg::*;
#(
    parameter int unsigned W = DIV_WIDTH + 1
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    localparam int unsigned NG = (W + DIV_GRP_W - 1) / DIV_GRP_W;
    localparam int unsigned PW = NG * DIV_GRP_W;

    logic [PW-1:0] a_ext, bn_ext, p, g, sum_w;
    logic [NG-1:0] gg, gp;
    logic [NG:0]   gc;
    logic          unused_sum_pad;

    // Zero-extended operands: carry-out of the padded adder still means a >= b.
    assign a_ext  = PW'(a_i);
    assign bn_ext = ~PW'(b_i);
    assign p      = a_ext ^ bn_ext;
    assign g      = a_ext & bn_ext;

    always_comb begin : grp_pg
        gg = '0;
        gp = '1;
        for (int unsigned gi = 0; gi < NG; gi++) begin
            for (int unsigned j = 0; j < DIV_GRP_W; j++) begin
                gg[gi] = g[gi*DIV_GRP_W + j] | (p[gi*DIV_GRP_W + j] & gg[gi]);
                gp[gi] = gp[gi] & p[gi*DIV_GRP_W + j];
            end
        end
    end

    always_comb begin : grp_carry
        logic t;
        t  = 1'b0;
        gc = '0;
        gc[0] = 1'b1;
        for (int unsigned gi = 1; gi <= NG; gi++) begin
            t = 1'b1;
            for (int unsigned k = 0; k < gi; k++) begin
                t = t & gp[k];
            end
            gc[gi] = t;
            for (int unsigned k = 0; k < gi; k++) begin
                t = gg[k];
                for (int unsigned m = k + 1; m < gi; m++) begin
                    t = t & gp[m];
                end
                gc[gi] = gc[gi] | t;
            end
        end
    end

    always_comb begin : bit_sum
        logic c;
        c     = 1'b0;
        sum_w = '0;
        for (int unsigned gi = 0; gi < NG; gi++) begin
            c = gc[gi];
            for (int unsigned j = 0; j < DIV_GRP_W; j++) begin
                sum_w[gi*DIV_GRP_W + j] = p[gi*DIV_GRP_W + j] ^ c;
                c = g[gi*DIV_GRP_W + j] | (p[gi*DIV_GRP_W + j] & c);
            end
        end
    end

    assign diff_o         = sum_w[W-1:0];
    assign borrow_o       = ~gc[NG];
    assign unused_sum_pad = ^sum_w;

endmodule

// File: rtl/iter_divider.sv
// Restoring shift-subtract divider, one quotient bit per cycle.
// Optional signed mode under `define DIV_SIGNED_EN.
module iter_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             op_signed,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int unsigned CNT_W = div_cnt_w(WIDTH);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] n_q, n_d, d_q, d_d, q_q, q_d, r_q, r_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   r_shift, t_diff;
    logic             t_borrow;
    logic [WIDTH-1:0] q_iter, r_iter, q_fix, r_fix, dvd_mag, dsr_mag;
    logic             accept;
    logic             unused_t_msb;

    assign accept  = (state_q == S_IDLE) && req_valid;
    // One extra bit on top keeps the shifted remainder exact for divisors >= 2^(WIDTH-1).
    assign r_shift = {r_q, n_q[WIDTH-1]};

    iter_sub_cla #(.W(WIDTH + 1)) u_sub (
        .a_i      (r_shift),
        .b_i      ({1'b0, d_q}),
        .diff_o   (t_diff),
        .borrow_o (t_borrow)
    );

    assign q_iter       = {q_q[WIDTH-2:0], ~t_borrow};
    assign r_iter       = t_borrow ? r_shift[WIDTH-1:0] : t_diff[WIDTH-1:0];
    assign unused_t_msb = t_diff[WIDTH];

`ifdef DIV_SIGNED_EN
    logic neg_q_q, neg_q_d, neg_r_q, neg_r_d;

    assign dvd_mag = (op_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign dsr_mag = (op_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    assign neg_q_d = accept ? (op_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1])) : neg_q_q;
    assign neg_r_d = accept ? (op_signed && dividend[WIDTH-1]) : neg_r_q;
    assign q_fix   = neg_q_q ? -q_iter : q_iter;
    assign r_fix   = neg_r_q ? -r_iter : r_iter;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else begin
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
        end
    end
`else
    logic unused_op_signed;

    assign unused_op_signed = op_signed;
    assign dvd_mag          = dividend;
    assign dsr_mag          = divisor;
    assign q_fix            = q_iter;
    assign r_fix            = r_iter;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        d_d     = d_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (divisor == '0) begin
                        state_d = S_DONE;
                        q_d     = '1;
                        r_d     = dividend;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        n_d     = dvd_mag;
                        d_d     = dsr_mag;
                        q_d     = '0;
                        r_d     = '0;
                    end
                end
            end
            S_RUN: begin
                n_d = {n_q[WIDTH-2:0], 1'b0};
                // Final step folds the sign fix-up in so latency matches the unsigned path.
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    q_d     = q_fix;
                    r_d     = r_fix;
                end else begin
                    q_d   = q_iter;
                    r_d   = r_iter;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                    dz_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            d_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            d_q     <= d_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign quotient   = q_q;
    assign remainder  = r_q;
    assign div_zero   = dz_q;

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider; signed cases are built when DIV_SIGNED_EN is defined.
module tb_iter_divider;
    import div_pkg::*;

    localparam int unsigned W = DIV_WIDTH;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         op_signed = 1'b0;
    logic         resp_ready = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         req_ready, resp_valid, div_zero;
    logic [W-1:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t scb[$];

    always #5 clk = ~clk;

    iter_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .op_signed  (op_signed),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_zero   (div_zero)
    );

    function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
        exp_t e;
        e.q  = q;
        e.r  = r;
        e.dz = dz;
        return e;
    endfunction

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        exp_t e;
        int   sa, sb;
        e.dz = 1'b0;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else if (sgn) begin
            sa  = $signed(a);
            sb  = $signed(b);
            e.q = W'(sa / sb);
            e.r = W'(sa % sb);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn, input exp_t e);
        int n;
        @(negedge clk);
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: req_ready=%b required 1", req_ready);
        end
        dividend  = a;
        divisor   = b;
        op_signed = sgn;
        req_valid = 1'b1;
        scb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic recv(input int exp_lat, input string tag);
        int   cyc;
        exp_t e;
        cyc = 1;
        @(negedge clk);
        while (resp_valid !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: resp_valid=%b required 1 within 100 cycles", tag, resp_valid);
        end
        if (exp_lat > 0) begin
            checks++;
            if (cyc != exp_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d cycles required %0d", tag, cyc, exp_lat);
            end
        end
        checks++;
        if (scb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got empty queue required one entry", tag);
        end else begin
            e = scb.pop_front();
            if (quotient !== e.q) begin
                errors++;
                $display("FAIL %s quotient: got %h required %h", tag, quotient, e.q);
            end
            checks++;
            if (remainder !== e.r) begin
                errors++;
                $display("FAIL %s remainder: got %h required %h", tag, remainder, e.r);
            end
            checks++;
            if (div_zero !== e.dz) begin
                errors++;
                $display("FAIL %s div_zero: got %b required %b", tag, div_zero, e.dz);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s post_handshake: resp_valid=%b req_ready=%b required 0 1", tag, resp_valid, req_ready);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL %s flags: req_ready=%b resp_valid=%b div_zero=%b required 1 0 0",
                     tag, req_ready, resp_valid, div_zero);
        end
        checks++;
        if (quotient !== '0 || remainder !== '0) begin
            errors++;
            $display("FAIL %s data: quotient=%h remainder=%h required 0000 0000", tag, quotient, remainder);
        end
    endtask

    task automatic test_reset();
        #1;
        check_reset_values("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        send(16'd100, 16'd7, 1'b0, mk(16'd14, 16'd2, 1'b0));
        recv(17, "u100_7");
        send(16'hFFFF, 16'h0001, 1'b0, mk(16'hFFFF, 16'h0000, 1'b0));
        recv(17, "uFFFF_1");
        send(16'h1234, 16'hFFFF, 1'b0, mk(16'h0000, 16'h1234, 1'b0));
        recv(17, "u1234_FFFF");
        send(16'h8000, 16'h8000, 1'b0, mk(16'h0001, 16'h0000, 1'b0));
        recv(17, "u8000_8000");
    endtask

    task automatic test_div_zero();
        send(16'h00AB, 16'h0000, 1'b0, mk(DIV_ZERO_Q, 16'h00AB, 1'b1));
        recv(1, "dz_00AB");
    endtask

    task automatic test_backpressure();
        logic [W-1:0] hq, hr;
        logic         hdz;
        int           n;
        send(16'd200, 16'd9, 1'b0, mk(16'd22, 16'd2, 1'b0));
        n = 0;
        @(negedge clk);
        while (resp_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        hq  = quotient;
        hr  = remainder;
        hdz = div_zero;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                req_valid = 1'b1;
                dividend  = 16'd1;
                divisor   = 16'd1;
            end
            if (i == 2) req_valid = 1'b0;
            checks++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: resp_valid=%b req_ready=%b required 1 0", i, resp_valid, req_ready);
            end
            checks++;
            if (quotient !== hq || remainder !== hr || div_zero !== hdz) begin
                errors++;
                $display("FAIL bp_stable%0d: got %h %h %b required %h %h %b",
                         i, quotient, remainder, div_zero, hq, hr, hdz);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        recv(0, "bp_200_9");
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL bp_ignored_req: got %0d cycles with resp_valid required 0", n);
        end
    endtask

    task automatic test_async_reset();
        int seen;
        send(16'd50, 16'd3, 1'b0, mk(16'd16, 16'd2, 1'b0));
        void'(scb.pop_back());
        repeat (8) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL arst_running: req_ready=%b required 0", req_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("arst");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL arst_no_resp: got %0d cycles with resp_valid required 0", seen);
        end
        send(16'd9, 16'd4, 1'b0, mk(16'd2, 16'd1, 1'b0));
        recv(17, "arst_9_4");
    endtask

    task automatic test_signed();
`ifdef DIV_SIGNED_EN
        send(16'hFFF9, 16'h0002, 1'b1, mk(16'hFFFD, 16'hFFFF, 1'b0));
        recv(17, "s_m7_2");
        send(16'h0007, 16'hFFFE, 1'b1, mk(16'hFFFD, 16'h0001, 1'b0));
        recv(17, "s_7_m2");
        send(16'h8000, 16'hFFFF, 1'b1, mk(16'h8000, 16'h0000, 1'b0));
        recv(17, "s_min_m1");
        send(16'hFF55, 16'h0000, 1'b1, mk(DIV_ZERO_Q, 16'hFF55, 1'b1));
        recv(1, "s_dz");
        send(16'hFFF9, 16'h0002, 1'b0, mk(16'h7FFC, 16'h0001, 1'b0));
        recv(17, "s_off_m7_2");
`else
        send(16'hFFF9, 16'h0002, 1'b1, mk(16'h7FFC, 16'h0001, 1'b0));
        recv(17, "u_opsigned_ignored");
`endif
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n;
        send(16'd1000, 16'd10, 1'b0, mk(16'd100, 16'd0, 1'b0));
        n = 0;
        @(negedge clk);
        while (resp_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        e = scb.pop_front();
        checks++;
        if (resp_valid !== 1'b1 || quotient !== e.q || remainder !== e.r) begin
            errors++;
            $display("FAIL b2b_first: valid=%b q=%h r=%h required 1 %h %h", resp_valid, quotient, remainder, e.q, e.r);
        end
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        dividend   = 16'd77;
        divisor    = 16'd5;
        op_signed  = 1'b0;
        scb.push_back(mk(16'd15, 16'd2, 1'b0));
        @(posedge clk);
        #1 resp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_bypass: req_ready=%b resp_valid=%b required 1 0", req_ready, resp_valid);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: req_ready=%b required 0", req_ready);
        end
        recv(17, "b2b_second");
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic         sgn, sgn_eff;
        for (int i = 0; i < 24; i++) begin
            a = W'($urandom);
            if (i % 6 == 0)      b = '0;
            else if (i % 3 == 1) b = W'($urandom_range(1, 15));
            else                 b = W'($urandom);
            sgn = 1'(i % 2);
`ifdef DIV_SIGNED_EN
            sgn_eff = sgn;
`else
            sgn_eff = 1'b0;
`endif
            send(a, b, sgn, model(a, b, sgn_eff));
            recv((b == '0) ? 1 : 17, $sformatf("rnd%0d_%h_%h_s%0b", i, a, b, sgn));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unsigned();
        test_div_zero();
        test_backpressure();
        test_async_reset();
        test_signed();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
